rf_access_unit: RTL

Port controller on the datapath side of the 32×32 register file (`RF`) in the multicycle CPU. It sequences operand reads for the control unit and drives the RF write port from a 4-entry writeback buffer. It forwards buffered writes to reads so that results are never stale. It is the sole master of the RF `rr1`/`rr2`/`wr`/`wd`/`w` pins.

---
 rtl/rf_access_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/rf_access_unit.sv
// rtl/rf_access_unit.sv - register file port controller: operand read sequencer and writeback buffer
//
// Purpose:
//   Sole master of the register file pins. A three-state read sequencer fetches
//   two operands per request. A DEPTH-entry writeback FIFO drains one entry per
//   cycle into the RF write port. Buffered and same-cycle writebacks are forwarded
//   into operand reads, so a read never returns a stale value.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/ready     operand read request handshake, req_rs/req_rt source registers
//   rsp_valid/ready     operand response handshake, rsp_a/rsp_b operand values
//   wb_valid/ready      writeback handshake, wb_reg/wb_data destination and result
//   wb_stall            hold off RF writes (buffer keeps filling)
//   rr1, rr2 / rd1, rd2 RF read addresses / combinational RF read data
//   wr, wd, w           RF write port (RF writes at posedge when w=1)

module rf_access_unit #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_a,
    output logic [31:0] rsp_b,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    input  logic        wb_stall,
    output logic [4:0]  rr1,
    output logic [4:0]  rr2,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    output logic [4:0]  wr,
    output logic [31:0] wd,
    output logic        w
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t        r_state;
    logic [4:0]    r_rs;
    logic [4:0]    r_rt;

    logic [4:0]    r_buf_reg  [DEPTH];
    logic [31:0]   r_buf_data [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;

    logic          w_wb_hs;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_fwd_a;
    logic [31:0]   w_fwd_b;

    // ------------------------------------------------------------------
    // Handshakes and RF write port
    // ------------------------------------------------------------------
    assign wb_ready = (r_count < (AW+1)'(DEPTH));
    assign w_wb_hs  = wb_valid & wb_ready;
    // Writes to r0 complete the handshake but never occupy a slot.
    assign w_push   = w_wb_hs & (wb_reg != 5'd0);
    assign w_pop    = (r_count != '0) & ~wb_stall;

    assign w  = w_pop;
    assign wr = w_pop ? r_buf_reg[r_head]  : 5'd0;
    assign wd = w_pop ? r_buf_data[r_head] : 32'd0;

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rr1       = (r_state == S_FETCH) ? r_rs : 5'd0;
    assign rr2       = (r_state == S_FETCH) ? r_rt : 5'd0;

    // ------------------------------------------------------------------
    // Operand forwarding. Entries are scanned oldest to youngest so the
    // youngest match wins; the head is included even while it drains, which
    // covers the cycle where the RF has not yet taken the write. A same-cycle
    // writeback handshake overrides the buffer, and r0 overrides everything.
    // ------------------------------------------------------------------
    always_comb begin
        w_fwd_a = rd1;
        w_fwd_b = rd2;
        w_idx   = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + AW'(i);
            if ((AW+1)'(i) < r_count) begin
                if (r_buf_reg[w_idx] == r_rs) begin
                    w_fwd_a = r_buf_data[w_idx];
                end
                if (r_buf_reg[w_idx] == r_rt) begin
                    w_fwd_b = r_buf_data[w_idx];
                end
            end
        end
        if (w_wb_hs && (wb_reg == r_rs)) begin
            w_fwd_a = wb_data;
        end
        if (w_wb_hs && (wb_reg == r_rt)) begin
            w_fwd_b = wb_data;
        end
        if (r_rs == 5'd0) begin
            w_fwd_a = 32'd0;
        end
        if (r_rt == 5'd0) begin
            w_fwd_b = 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Read sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rs    <= 5'd0;
            r_rt    <= 5'd0;
            rsp_a   <= 32'd0;
            rsp_b   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_rs    <= req_rs;
                        r_rt    <= req_rt;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    rsp_a   <= w_fwd_a;
                    rsp_b   <= w_fwd_b;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Writeback FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_reg[i]  <= 5'd0;
                r_buf_data[i] <= 32'd0;
            end
        end else begin
            if (w_push) begin
                r_buf_reg[r_tail]  <= wb_reg;
                r_buf_data[r_tail] <= wb_data;
                r_tail             <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
